// File: rtl/operand_fetch_stage_pkg.sv
// operand_fetch_stage_pkg: shared types and defaults for the operand fetch stage
package operand_fetch_stage_pkg;
  localparam int XLEN_DEF = 32;
  typedef logic [4:0] reg_addr_t;
  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] instr;
    logic [XLEN_DEF-1:0] rs1_value;
    logic [XLEN_DEF-1:0] rs2_value;
    reg_addr_t           rd;
    logic                rd_we;
  } issue_t;
endpackage

// File: rtl/register_scoreboard.sv
// register_scoreboard: per-register busy bits; set beats clear, x0 never busy
module register_scoreboard
  import operand_fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        set,
  input  reg_addr_t   set_addr,
  input  logic        clr,
  input  reg_addr_t   clr_addr,
  input  logic        flush,
  output logic [31:0] busy
);
  logic [31:0] set_mask, clr_mask;
  always_comb begin
    set_mask = set ? 32'b1 << set_addr : 32'b0;
    clr_mask = clr ? 32'b1 << clr_addr : 32'b0;
  end
  always_ff @(posedge clk) begin
    if (!rst || flush) busy <= '0;
    else busy <= ((busy & ~clr_mask) | set_mask) & ~32'b1;
  end
endmodule

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: reads operands, blocks on scoreboard hazards, issues to execute.
// Define OPERAND_BYPASS_EN to forward same-cycle writeback data into the operands.
module operand_fetch_stage
  import operand_fetch_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_instr,
  input  reg_addr_t       in_rs1,
  input  reg_addr_t       in_rs2,
  input  reg_addr_t       in_rd,
  input  logic            in_rd_we,
  output reg_addr_t       rf_read_address1,
  output reg_addr_t       rf_read_address2,
  input  logic [XLEN-1:0] rf_read_data1,
  input  logic [XLEN-1:0] rf_read_data2,
  input  logic            wb_valid,
  input  reg_addr_t       wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_rs1_value,
  output logic [XLEN-1:0] out_rs2_value,
  output reg_addr_t       out_rd,
  output logic            out_rd_we
);
  logic [31:0] busy;
  logic byp1, byp2, haz1, haz2, waw, accept;
  logic [XLEN-1:0] op1, op2;
`ifdef OPERAND_BYPASS_EN
  assign byp1 = wb_valid && wb_rd == in_rs1 && in_rs1 != '0;
  assign byp2 = wb_valid && wb_rd == in_rs2 && in_rs2 != '0;
`else
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif
  assign rf_read_address1 = in_rs1;
  assign rf_read_address2 = in_rs2;
  always_comb begin
    haz1 = in_rs1 != '0 && busy[in_rs1] && !byp1;
    haz2 = in_rs2 != '0 && busy[in_rs2] && !byp2;
    waw = in_rd_we && in_rd != '0 && busy[in_rd] && !(wb_valid && wb_rd == in_rd);
    in_ready = rst && (!out_valid || out_ready) && !(haz1 || haz2 || waw) && !flush;
    accept = in_valid && in_ready;
    op1 = in_rs1 == '0 ? '0 : byp1 ? wb_data : rf_read_data1;
    op2 = in_rs2 == '0 ? '0 : byp2 ? wb_data : rf_read_data2;
  end
  register_scoreboard u_sb (
    .clk     (clk),
    .rst     (rst),
    .set     (accept && in_rd_we),
    .set_addr(in_rd),
    .clr     (wb_valid),
    .clr_addr(wb_rd),
    .flush   (flush),
    .busy    (busy)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid     <= 1'b0;
      out_pc        <= '0;
      out_instr     <= '0;
      out_rs1_value <= '0;
      out_rs2_value <= '0;
      out_rd        <= '0;
      out_rd_we     <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      out_pc        <= in_pc;
      out_instr     <= in_instr;
      out_rs1_value <= op1;
      out_rs2_value <= op2;
      out_rd        <= in_rd;
      out_rd_we     <= in_rd_we;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb_operand_fetch_stage: directed checks of issue, hazards, stalls, flush and reset
module tb_operand_fetch_stage;
  logic clk = 0, rst = 0;
  logic in_valid = 0, in_ready, in_rd_we = 0;
  logic [31:0] in_pc = 0, in_instr = 0, rf_read_data1, rf_read_data2, wb_data = 0;
  logic [4:0] in_rs1 = 0, in_rs2 = 0, in_rd = 0, rf_read_address1, rf_read_address2, wb_rd = 0, out_rd;
  logic wb_valid = 0, flush = 0, out_valid, out_ready = 0, out_rd_we;
  logic [31:0] out_pc, out_instr, out_rs1_value, out_rs2_value;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  // register file model: value of xN is N + 0xE
  assign rf_read_data1 = {27'b0, rf_read_address1} + 32'hE;
  assign rf_read_data2 = {27'b0, rf_read_address2} + 32'hE;
  operand_fetch_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rd(in_rd), .in_rd_we(in_rd_we),
    .rf_read_address1(rf_read_address1), .rf_read_address2(rf_read_address2),
    .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_rs1_value(out_rs1_value), .out_rs2_value(out_rs2_value),
    .out_rd(out_rd), .out_rd_we(out_rd_we)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic we);
    in_valid = 1; in_pc = pc; in_instr = pc ^ 32'hA5A5_0000;
    in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rd_we = we;
  endtask
  task automatic test_reset();
    rst = 0;
    drive(32'h50, 5'd1, 5'd2, 5'd3, 1'b1);
    out_ready = 1;
    step(); step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (dut.busy !== 32'h0) begin errors++; $display("FAIL reset_busy got %h want 0", dut.busy); end
    checks++; if (out_pc !== 32'h0 || out_rd !== 5'd0) begin errors++; $display("FAIL reset_payload got pc=%h rd=%0d want 0", out_pc, out_rd); end
    in_valid = 0;
  endtask
  task automatic test_issue();
    rst = 1;
    drive(32'h100, 5'd3, 5'd0, 5'd5, 1'b1);
    #1;
    checks++; if (in_ready !== 1'b1 || rf_read_address1 !== 5'd3) begin errors++; $display("FAIL issue_ready got rdy=%b a1=%0d want 1/3", in_ready, rf_read_address1); end
    step();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== 32'hA5A5_0100) begin errors++; $display("FAIL issue_out got v=%b pc=%h instr=%h want 1/100/a5a50100", out_valid, out_pc, out_instr); end
    checks++; if (out_rs1_value !== 32'h11 || out_rs2_value !== 32'h0) begin errors++; $display("FAIL issue_ops got %h/%h want 11/0", out_rs1_value, out_rs2_value); end
    checks++; if (out_rd !== 5'd5 || out_rd_we !== 1'b1 || dut.busy !== 32'h20) begin errors++; $display("FAIL issue_busy got rd=%0d we=%b busy=%h want 5/1/20", out_rd, out_rd_we, dut.busy); end
  endtask
  task automatic test_src_hazard();
    drive(32'h104, 5'd5, 5'd0, 5'd6, 1'b1);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL haz_ready got %b want 0", in_ready); end
    step();
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL haz_hold got rdy=%b v=%b want 0/0", in_ready, out_valid); end
    wb_valid = 1; wb_rd = 5; wb_data = 32'hAB;
    #1;
`ifdef OPERAND_BYPASS_EN
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL haz_bypass_ready got %b want 1", in_ready); end
    step();
    wb_valid = 0;
    checks++; if (out_valid !== 1'b1 || out_rs1_value !== 32'hAB) begin errors++; $display("FAIL haz_bypass_val got v=%b op=%h want 1/ab", out_valid, out_rs1_value); end
`else
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL haz_wb_ready got %b want 0", in_ready); end
    step();
    wb_valid = 0;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL haz_after_wb got rdy=%b v=%b want 1/0", in_ready, out_valid); end
    step();
    checks++; if (out_valid !== 1'b1 || out_rs1_value !== 32'h13) begin errors++; $display("FAIL haz_rf_val got v=%b op=%h want 1/13", out_valid, out_rs1_value); end
`endif
    checks++; if (dut.busy !== 32'h40 || out_pc !== 32'h104) begin errors++; $display("FAIL haz_busy got busy=%h pc=%h want 40/104", dut.busy, out_pc); end
  endtask
  task automatic test_stall();
    out_ready = 0;
    drive(32'h108, 5'd1, 5'd2, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h104 || out_rd !== 5'd6) begin errors++; $display("FAIL stall_%0d got rdy=%b v=%b pc=%h rd=%0d want 0/1/104/6", i, in_ready, out_valid, out_pc, out_rd); end
      step();
    end
    out_ready = 1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release got %b want 1", in_ready); end
    step();
    in_valid = 0;
    checks++; if (out_pc !== 32'h108 || out_rs1_value !== 32'hF || out_rs2_value !== 32'h10 || out_rd_we !== 1'b0) begin errors++; $display("FAIL stall_next got pc=%h ops=%h/%h we=%b want 108/f/10/0", out_pc, out_rs1_value, out_rs2_value, out_rd_we); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain got %b want 0", out_valid); end
  endtask
  task automatic test_waw();
    drive(32'h200, 5'd0, 5'd0, 5'd7, 1'b1);
    step();
    drive(32'h204, 5'd0, 5'd0, 5'd7, 1'b1);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL waw_block got %b want 0", in_ready); end
    wb_valid = 1; wb_rd = 7; wb_data = 32'h77;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL waw_wb_ready got %b want 1", in_ready); end
    step();
    wb_valid = 0; in_valid = 0;
    checks++; if (dut.busy !== 32'hC0 || out_pc !== 32'h204 || out_valid !== 1'b1) begin errors++; $display("FAIL waw_set_wins got busy=%h pc=%h v=%b want c0/204/1", dut.busy, out_pc, out_valid); end
  endtask
  task automatic test_flush();
    drive(32'h300, 5'd0, 5'd0, 5'd4, 1'b1);
    step();
    drive(32'h304, 5'd0, 5'd0, 5'd9, 1'b1);
    step();
    checks++; if (dut.busy !== 32'h2D0 || out_valid !== 1'b1) begin errors++; $display("FAIL flush_pre got busy=%h v=%b want 2d0/1", dut.busy, out_valid); end
    drive(32'h308, 5'd0, 5'd0, 5'd10, 1'b1);
    flush = 1; wb_valid = 1; wb_rd = 4;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", in_ready); end
    step();
    flush = 0; wb_valid = 0; in_valid = 0;
    checks++; if (out_valid !== 1'b0 || dut.busy !== 32'h0) begin errors++; $display("FAIL flush_clear got v=%b busy=%h want 0/0", out_valid, dut.busy); end
  endtask
  task automatic test_reset_mid();
    out_ready = 0;
    drive(32'h400, 5'd1, 5'd2, 5'd12, 1'b1);
    step();
    drive(32'h404, 5'd3, 5'd4, 5'd13, 1'b1);
    rst = 0; wb_valid = 1; wb_rd = 12;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready got %b want 0", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0 || out_pc !== 0 || out_instr !== 0 || out_rs1_value !== 0 || out_rs2_value !== 0 || out_rd !== 0 || out_rd_we !== 0 || dut.busy !== 0) begin errors++; $display("FAIL rst_mid_outs got v=%b pc=%h busy=%h want all 0", out_valid, out_pc, dut.busy); end
    rst = 1; wb_valid = 0; out_ready = 1;
    drive(32'h500, 5'd0, 5'd0, 5'd8, 1'b1);
    step();
    in_valid = 0; wb_valid = 1; wb_rd = 0;
    step();
    wb_valid = 0;
    checks++; if (dut.busy !== 32'h100) begin errors++; $display("FAIL wb_x0 got busy=%h want 100", dut.busy); end
  endtask
  initial begin
    test_reset();
    test_issue();
    test_src_hazard();
    test_stall();
    test_waw();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/operand_fetch_stage.md
OPERAND_FETCH_STAGE -- requirements
Module: operand_fetch_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/PC width; no other parameters.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-low (asserted when 0, sampled on posedge clk).
REQ-004 SHALL have ports in_valid/in_ready  input/output  1/1  upstream decode handshake.
REQ-005 SHALL have ports in_pc, in_instr  input  XLEN each  decoded instruction payload.
REQ-006 SHALL have ports in_rs1, in_rs2, in_rd  input  5 each; in_rd_we  input  1  instruction writes rd.
REQ-007 SHALL have ports rf_read_address1/2  output  5 each; rf_read_data1/2  input  XLEN each  combinational register-file read ports.
REQ-008 SHALL have ports wb_valid  input  1; wb_rd  input  5; wb_data  input  XLEN  writeback commit, same cycle as the register-file write.
REQ-009 SHALL have port flush  input  1  discard in-flight state.
REQ-010 SHALL have ports out_valid/out_ready  output/input  1/1  downstream execute handshake.
REQ-011 SHALL have ports out_pc, out_instr, out_rs1_value, out_rs2_value  output  XLEN each; out_rd  output  5; out_rd_we  output  1.

Function
REQ-012 SHALL drive rf_read_address1 = in_rs1 and rf_read_address2 = in_rs2 combinationally.
REQ-013 SHALL hold a 32-bit busy scoreboard; busy[0] SHALL read 0 at all times.
REQ-014 Source hazard SHALL exist for rsN when rsN != 0, busy[rsN] = 1, and rsN is not bypassed (REQ-026).
REQ-015 WAW hazard SHALL exist when in_rd_we = 1, in_rd != 0, busy[in_rd] = 1, and not (wb_valid and wb_rd == in_rd).
REQ-016 in_ready SHALL be (!out_valid || out_ready) && !hazard && !flush; accept = in_valid && in_ready.
REQ-017 On accept, the output register SHALL load all out_* fields and set out_valid = 1 at the next edge (latency 1 cycle).
REQ-018 When out_valid && out_ready and no accept, out_valid SHALL clear at the next edge; out_* SHALL remain stable while out_valid && !out_ready.
REQ-019 Operand value SHALL be 0 when rsN == 0, wb_data when bypassed, else rf_read_dataN.
REQ-020 On accept with in_rd_we and in_rd != 0, busy[in_rd] SHALL set; wb_valid with wb_rd != 0 SHALL clear busy[wb_rd]; same-register set and clear in one cycle: set wins.
REQ-021 wb_valid with wb_rd == 0 SHALL be ignored.
REQ-022 flush SHALL, at the next edge, clear out_valid and the entire scoreboard, overriding accept and writeback; in_ready SHALL be 0 during flush.

Reset
REQ-023 While rst = 0 at a clock edge: out_valid, busy, out_pc, out_instr, out_rs1_value, out_rs2_value, out_rd, out_rd_we SHALL all become 0.
REQ-024 in_ready SHALL be 0 during reset; reset SHALL override flush, accept and writeback, including mid-handshake.
REQ-025 First accept SHALL be possible in the first cycle after rst returns to 1.

Configuration
REQ-026 With OPERAND_BYPASS_EN defined, rsN SHALL be bypassed when wb_valid and wb_rd == rsN != 0, removing that source hazard and selecting wb_data.
REQ-027 Without OPERAND_BYPASS_EN, no bypass SHALL occur; source hazard persists until the cycle after the writeback clears busy.

Structure
REQ-028 Shared package SHALL hold reg_addr_t (5-bit), the XLEN default, and a packed struct for the issued-instruction bundle (pc, instr, rs1/rs2 values, rd, rd_we).
REQ-029 Scoreboard SHALL be a sub-module named register_scoreboard (set/clear/flush ports, busy vector output).

Verification
REQ-030 Reset then in_valid, rs1=3, rs2=0, rd=5, rd_we=1, rf_read_data1=0x11 -> next cycle out_valid=1, out_rs1_value=0x11, out_rs2_value=0, busy[5]=1.
REQ-031 Following instruction rs1=5, no wb -> in_ready=0 held; wb_valid, wb_rd=5, wb_data=0xAB -> with macro accepted that cycle, out_rs1_value=0xAB; without macro accepted next cycle.
REQ-032 out_ready=0 with out_valid=1 for 3 cycles -> in_ready=0 and out_* unchanged; out_ready=1 -> pending input accepted same cycle.
REQ-033 busy[7]=1, new instr rd=7 rd_we=1 with wb_rd=7 same cycle -> accepted, busy[7] remains 1.
REQ-034 flush asserted with out_valid=1 and busy[4]=1, busy[9]=1 -> next cycle out_valid=0, busy all 0, in_ready=0 during flush.
REQ-035 rst=0 asserted mid-stall with out_valid=1 -> next edge all outputs 0; wb_rd=0, wb_valid=1 -> no scoreboard change.
